// File: rtl/debounce_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, the
// bounce-counter ceiling and a saturating increment helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [7:0] BOUNCE_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == BOUNCE_MAX) ? BOUNCE_MAX : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Plain flip-flop synchroniser chain for an asynchronous single-bit level.
// No logic sits between stages so the metastability settling time is maximised.
module sync_ff #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{INIT}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Turns a bouncing push-button level into a clean synchronous level that only
// moves after the new level has held for DEBOUNCE_CYCLES clocks; counts aborts.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 20,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_out,
  output logic       key_stable,
  output logic [7:0] bounce_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("key_debounce: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
    end
  endgenerate

  logic             key_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic             out_nxt;
  logic [7:0]       bounce_nxt;

  sync_ff #(
    .STAGES(SYNC_STAGES),
    .INIT  (INIT_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_in),
    .q  (key_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_LEVEL ? IDLE_HI : IDLE_LO;
      counter    <= '0;
      key_out    <= INIT_LEVEL;
      key_stable <= 1'b1;
      bounce_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      key_out    <= out_nxt;
      key_stable <= (state_nxt == IDLE_LO) || (state_nxt == IDLE_HI);
      bounce_cnt <= bounce_nxt;
    end
  end

  // A reversal on the qualifying cycle is treated as an abort, never a change.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    out_nxt     = key_out;
    bounce_nxt  = bounce_cnt;
    case (state)
      IDLE_LO: begin
        if (key_sync) begin
          state_nxt   = WAIT_HI;
          counter_nxt = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!key_sync) begin
          state_nxt   = IDLE_LO;
          counter_nxt = '0;
          bounce_nxt  = sat_inc(bounce_cnt);
        end else if (counter == LAST) begin
          state_nxt   = IDLE_HI;
          counter_nxt = '0;
          out_nxt     = 1'b1;
        end else begin
          counter_nxt = counter + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!key_sync) begin
          state_nxt   = WAIT_LO;
          counter_nxt = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (key_sync) begin
          state_nxt   = IDLE_HI;
          counter_nxt = '0;
          bounce_nxt  = sat_inc(bounce_cnt);
        end else if (counter == LAST) begin
          state_nxt   = IDLE_LO;
          counter_nxt = '0;
          out_nxt     = 1'b0;
        end else begin
          counter_nxt = counter + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE_LO;
        counter_nxt = '0;
        out_nxt     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected outputs are queued with the edge
// on which they are due and compared when the bench reaches that edge.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       key_out;
  logic       key_stable;
  logic [7:0] bounce_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises = 0;
  logic prev_out = 1'b0;

  typedef struct {
    string      tag;
    int         due;
    logic       ko;
    logic       ks;
    logic [7:0] bc;
  } exp_t;

  exp_t sb[$];

  key_debounce dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_stable(key_stable),
    .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  // Stands in for the downstream edge detector: counts key_out rises.
  always @(negedge clk) begin
    if (key_out === 1'b1 && prev_out === 1'b0) rises++;
    prev_out = key_out;
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int offset, input logic ko,
                           input logic ks, input logic [7:0] bc);
    exp_t e;
    e.tag = tag; e.due = cyc + offset; e.ko = ko; e.ks = ks; e.bc = bc;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_val({e.tag, ".key_out"},    8'(key_out),    8'(e.ko));
      check_val({e.tag, ".key_stable"}, 8'(key_stable), 8'(e.ks));
      check_val({e.tag, ".bounce_cnt"}, bounce_cnt,     e.bc);
    end
  endtask

  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_output();
    end
  endtask

  // Called 1 ns after an edge; drives 4 ns after it.
  task automatic apply_stimulus(input logic v);
    #3;
    key_in = v;
  endtask

  initial begin
    int base;

    // Reset with key low.
    rst    = 1'b1;
    key_in = 1'b0;
    run_edges(5);
    expect_at("reset", 0, 1'b0, 1'b1, 8'd0);
    check_output();
    #3 rst = 1'b0;
    expect_at("post_reset", 1, 1'b0, 1'b1, 8'd0);
    run_edges(1);

    // Reset during a pending rise abandons it; rise follows 22 edges after release.
    apply_stimulus(1'b1);
    expect_at("mid_wait", 9, 1'b0, 1'b0, 8'd0);
    run_edges(9);
    #3 rst = 1'b1;
    expect_at("mid_rst", 1, 1'b0, 1'b1, 8'd0);
    run_edges(1);
    check_val("mid_rst.counter", 8'(dut.counter), 8'd0);
    #3 rst = 1'b0;
    expect_at("rst_rise_pre", 21, 1'b0, 1'b0, 8'd0);
    expect_at("rst_rise",     22, 1'b1, 1'b1, 8'd0);
    run_edges(25);

    // Clean release: falls on edge 22.
    apply_stimulus(1'b0);
    expect_at("fall_pre", 21, 1'b1, 1'b0, 8'd0);
    expect_at("fall",     22, 1'b0, 1'b1, 8'd0);
    run_edges(30);

    // Clean press held 40 clocks.
    base = rises;
    apply_stimulus(1'b1);
    expect_at("press_e2",  2,  1'b0, 1'b1, 8'd0);
    expect_at("press_e3",  3,  1'b0, 1'b0, 8'd0);
    expect_at("press_e21", 21, 1'b0, 1'b0, 8'd0);
    expect_at("press_e22", 22, 1'b1, 1'b1, 8'd0);
    run_edges(40);
    check_val("press.rise_count", 8'(rises - base), 8'd1);

    apply_stimulus(1'b0);
    expect_at("fall2", 22, 1'b0, 1'b1, 8'd0);
    run_edges(30);

    // Bounce: three 3-clock highs separated by 3-clock lows, then hold high.
    base = rises;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1);
      run_edges(3);
      apply_stimulus(1'b0);
      run_edges(3);
    end
    apply_stimulus(1'b1);
    expect_at("bounce_pre",  21, 1'b0, 1'b0, 8'd3);
    expect_at("bounce_rise", 22, 1'b1, 1'b1, 8'd3);
    run_edges(30);
    check_val("bounce.rise_count", 8'(rises - base), 8'd1);

    apply_stimulus(1'b0);
    expect_at("fall3", 22, 1'b0, 1'b1, 8'd3);
    run_edges(30);

    // Boundary: 19 clocks high is rejected, 20 clocks high is accepted.
    apply_stimulus(1'b1);
    run_edges(19);
    apply_stimulus(1'b0);
    expect_at("b19_pre",   2, 1'b0, 1'b0, 8'd3);
    expect_at("b19_abort", 3, 1'b0, 1'b1, 8'd4);
    run_edges(10);
    apply_stimulus(1'b1);
    expect_at("b20_pre",  21, 1'b0, 1'b0, 8'd4);
    expect_at("b20_rise", 22, 1'b1, 1'b1, 8'd4);
    run_edges(20);
    apply_stimulus(1'b0);
    expect_at("b20_fall", 22, 1'b0, 1'b1, 8'd4);
    run_edges(30);

    // Saturation: 300 two-clock glitches on top of the four aborts so far.
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1);
      run_edges(2);
      apply_stimulus(1'b0);
      run_edges(2);
    end
    expect_at("sat_100", 5, 1'b0, 1'b1, 8'd104);
    run_edges(5);
    for (int i = 0; i < 200; i++) begin
      apply_stimulus(1'b1);
      run_edges(2);
      apply_stimulus(1'b0);
      run_edges(2);
    end
    expect_at("sat_300", 10, 1'b0, 1'b1, 8'd255);
    run_edges(10);

    check_val("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
